mestre_polinomio: RTL and testbench

- Initiator/host for the polynomial datapath+control block (ports ck, inicio, pronto, rst, X, A, B, C, Resultado, LED).
- Buffers operand sets (X, A, B, C) from upstream in a small FIFO and issues them one at a time.
- Per operand set: pulses inicio, waits for LED, captures Resultado, acknowledges with pronto, presents the result to a downstream consumer via valid/accept.
- Replaces the hand-written stimulus currently used to drive the datapath.

---
 rtl/mestre_polinomio.sv | 155 +++++++++++++++
 tb/tb_mestre_polinomio.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mestre_polinomio.sv
// rtl/mestre_polinomio.sv - operand FIFO and handshake master for the polynomial datapath
// Optional LED timeout with sticky erro: define MESTRE_POLINOMIO_TIMEOUT_EN.
module mestre_polinomio #(
    parameter int LARG    = 16,
    parameter int PROF    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            op_valido,
    input  logic [LARG-1:0] op_X,
    input  logic [LARG-1:0] op_A,
    input  logic [LARG-1:0] op_B,
    input  logic [LARG-1:0] op_C,
    output logic            op_pronto,
    output logic            inicio,
    output logic            pronto,
    output logic [LARG-1:0] X,
    output logic [LARG-1:0] A,
    output logic [LARG-1:0] B,
    output logic [LARG-1:0] C,
    input  logic [LARG-1:0] Resultado,
    input  logic            LED,
    output logic [LARG-1:0] res,
    output logic            res_valido,
    input  logic            res_aceito,
    output logic            ocupado,
    output logic            erro
);
    localparam int AW = $clog2(PROF);
    localparam int EW = 4 * LARG;

    typedef enum logic [2:0] {OCIOSO, INICIA, ESPERA, PRONTO, SAIDA} estado_t;

    estado_t         estado_q, estado_d;
    logic [EW-1:0]   mem_q [PROF];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic            vazio, cheio, escreve, le;
    logic [LARG-1:0] x_q, x_d, a_q, a_d, b_q, b_d, c_q, c_d;
    logic [LARG-1:0] res_q, res_d;
    logic            tempo_esgotado;

    // Extra pointer bit separates full from empty when the index bits match.
    assign vazio   = (wr_ptr_q == rd_ptr_q);
    assign cheio   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign escreve = op_valido && !cheio;
    assign le      = (estado_q == OCIOSO) && !vazio;

    always_ff @(posedge ck) begin
        if (escreve) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {op_X, op_A, op_B, op_C};
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (escreve) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (le)      rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            estado_q <= OCIOSO;
            x_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            res_q    <= '0;
        end else begin
            estado_q <= estado_d;
            x_q      <= x_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        x_d      = x_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        res_d    = res_q;
        case (estado_q)
            OCIOSO: begin
                if (!vazio) begin
                    {x_d, a_d, b_d, c_d} = mem_q[rd_ptr_q[AW-1:0]];
                    estado_d = INICIA;
                end
            end
            INICIA: estado_d = ESPERA;
            ESPERA: begin
                if (LED) begin
                    res_d    = Resultado;
                    estado_d = PRONTO;
                end else if (tempo_esgotado) begin
                    // Reusing PRONTO with LED low yields a single-cycle pronto pulse.
                    res_d    = '0;
                    estado_d = PRONTO;
                end
            end
            PRONTO: begin
                if (!LED) estado_d = SAIDA;
            end
            SAIDA: begin
                if (res_aceito) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

`ifdef MESTRE_POLINOMIO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cont_q;
    logic          erro_q;

    assign tempo_esgotado = (estado_q == ESPERA) && (cont_q == CW'(TIMEOUT - 1));

    always_ff @(posedge ck) begin
        if (!rst) begin
            cont_q <= '0;
            erro_q <= 1'b0;
        end else begin
            if (estado_q == ESPERA && !LED) cont_q <= cont_q + CW'(1);
            else                            cont_q <= '0;
            if (tempo_esgotado && !LED) erro_q <= 1'b1;
        end
    end

    assign erro = erro_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign tempo_esgotado = 1'b0;
    assign erro           = 1'b0;
`endif

    assign op_pronto  = !cheio;
    assign inicio     = (estado_q == INICIA);
    assign pronto     = (estado_q == PRONTO);
    assign res_valido = (estado_q == SAIDA);
    assign ocupado    = (estado_q != OCIOSO) || !vazio;
    assign X          = x_q;
    assign A          = a_q;
    assign B          = b_q;
    assign C          = c_q;
    assign res        = res_q;

endmodule

// File: tb/tb_mestre_polinomio.sv
// tb/tb_mestre_polinomio.sv - directed bench for mestre_polinomio with a behavioural datapath
module tb_mestre_polinomio;
    logic        ck, rst, op_valido, op_pronto, inicio, pronto, LED;
    logic        res_valido, res_aceito, ocupado, erro;
    logic [15:0] op_X, op_A, op_B, op_C, X, A, B, C, Resultado, res;
    logic        dp_manual, man_led;
    logic [15:0] man_res;
    int          checks = 0;
    int          errors = 0;

    mestre_polinomio #(.LARG(16), .PROF(4), .TIMEOUT(8)) dut (
        .ck(ck), .rst(rst), .op_valido(op_valido),
        .op_X(op_X), .op_A(op_A), .op_B(op_B), .op_C(op_C),
        .op_pronto(op_pronto), .inicio(inicio), .pronto(pronto),
        .X(X), .A(A), .B(B), .C(C), .Resultado(Resultado), .LED(LED),
        .res(res), .res_valido(res_valido), .res_aceito(res_aceito),
        .ocupado(ocupado), .erro(erro)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic logic [15:0] poly(input logic [15:0] x, a, b, c);
        return a * x * x + b * x + c;
    endfunction

    // Datapath model: LED rises 3 cycles after inicio and drops once pronto is seen.
    initial begin
        LED = 1'b0;
        Resultado = '0;
        forever begin
            @(posedge ck); #2;
            if (dp_manual) begin
                LED = man_led;
                Resultado = man_res;
            end else if (inicio === 1'b1) begin
                repeat (3) @(posedge ck);
                #2;
                Resultado = poly(X, A, B, C);
                LED = 1'b1;
                for (int n = 0; n < 40 && pronto !== 1'b1; n++) begin
                    @(posedge ck); #2;
                end
                LED = 1'b0;
            end else begin
                LED = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge ck); #1;
    endtask

    task automatic push(input logic [15:0] x, a, b, c);
        int n;
        n = 0;
        op_X = x; op_A = a; op_B = b; op_C = c;
        op_valido = 1'b1;
        while (op_pronto !== 1'b1 && n < 50) begin step(); n++; end
        if (op_pronto !== 1'b1) begin
            checks++; errors++;
            $display("FAIL push_timeout: op_pronto=%b required 1", op_pronto);
        end
        step();
        op_valido = 1'b0;
    endtask

    task automatic wait_res(input int bound);
        int n;
        n = 0;
        while (res_valido !== 1'b1 && n < bound) begin step(); n++; end
        if (res_valido !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_res_timeout: res_valido=%b required 1", res_valido);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        checks++;
        if ({inicio, pronto, res_valido, erro, op_pronto, ocupado} !== 6'b000010) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000010",
                     {inicio, pronto, res_valido, erro, op_pronto, ocupado});
        end
        checks++;
        if ({X, A, B, C, res} !== 80'd0) begin
            errors++; $display("FAIL reset_data: got %h required 0", {X, A, B, C, res});
        end
        rst = 1'b1;
        step();
        checks++;
        if (op_pronto !== 1'b1 || ocupado !== 1'b0) begin
            errors++; $display("FAIL reset_release: op_pronto=%b ocupado=%b required 1/0", op_pronto, ocupado);
        end
    endtask

    task automatic test_single();
        int n, np;
        push(16'd2, 16'd3, 16'd4, 16'd5);
        checks++;
        if (inicio !== 1'b0 || ocupado !== 1'b1) begin
            errors++; $display("FAIL single_write: inicio=%b ocupado=%b required 0/1", inicio, ocupado);
        end
        step();
        checks++;
        if (inicio !== 1'b1 || {X, A, B, C} !== {16'd2, 16'd3, 16'd4, 16'd5}) begin
            errors++; $display("FAIL single_inicio: inicio=%b XABC=%h required 1/0002000300040005", inicio, {X, A, B, C});
        end
        step();
        checks++;
        if (inicio !== 1'b0) begin
            errors++; $display("FAIL single_pulse: inicio=%b required 0", inicio);
        end
        n = 0; np = 0;
        while (res_valido !== 1'b1 && n < 20) begin
            step(); n++;
            if (pronto === 1'b1) np++;
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL single_latency: got %0d required 4", n); end
        checks++;
        if (res !== 16'd25) begin errors++; $display("FAIL single_res: got %0d required 25", res); end
        checks++;
        if (np !== 1) begin errors++; $display("FAIL single_pronto: got %0d cycles required 1", np); end
        checks++;
        if ({X, A, B, C} !== {16'd2, 16'd3, 16'd4, 16'd5}) begin
            errors++; $display("FAIL single_operands: got %h", {X, A, B, C});
        end
        res_aceito = 1'b1;
        step();
        res_aceito = 1'b0;
        checks++;
        if (res_valido !== 1'b0) begin errors++; $display("FAIL single_accept: res_valido=%b required 0", res_valido); end
    endtask

    task automatic test_backpressure();
        push(16'd7, 16'd1, 16'd1, 16'd1);
        push(16'd2, 16'd0, 16'd0, 16'd9);
        wait_res(30);
        checks++;
        if (res !== 16'd57) begin errors++; $display("FAIL bp_res: got %0d required 57", res); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (res !== 16'd57 || res_valido !== 1'b1 || inicio !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d res=%0d res_valido=%b inicio=%b required 57/1/0", i, res, res_valido, inicio);
            end
        end
        res_aceito = 1'b1;
        step();
        res_aceito = 1'b0;
        checks++;
        if (res_valido !== 1'b0) begin errors++; $display("FAIL bp_accept: res_valido=%b required 0", res_valido); end
        step();
        checks++;
        if (inicio !== 1'b1 || X !== 16'd2) begin
            errors++; $display("FAIL bp_next: inicio=%b X=%0d required 1/2", inicio, X);
        end
        wait_res(30);
        checks++;
        if (res !== 16'd9) begin errors++; $display("FAIL bp_res2: got %0d required 9", res); end
        res_aceito = 1'b1;
        step();
        res_aceito = 1'b0;
    endtask

    task automatic test_fifo_fill();
        logic leaked;
        leaked = 1'b0;
        for (int k = 1; k <= 5; k++) push(16'(k), 16'(k + 1), 16'd2, 16'(3 * k));
        checks++;
        if (op_pronto !== 1'b0) begin errors++; $display("FAIL fill_full: op_pronto=%b required 0", op_pronto); end
        op_X = 16'd6; op_A = 16'd7; op_B = 16'd2; op_C = 16'd18;
        op_valido = 1'b1;
        for (int i = 0; i < 40 && res_valido !== 1'b1; i++) begin
            step();
            if (op_pronto !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked !== 1'b0) begin errors++; $display("FAIL fill_held: op_pronto rose=%b required 0", leaked); end
        checks++;
        if (res !== poly(16'd1, 16'd2, 16'd2, 16'd3)) begin
            errors++; $display("FAIL fill_res1: got %0d required %0d", res, poly(16'd1, 16'd2, 16'd2, 16'd3));
        end
        res_aceito = 1'b1;
        step();
        res_aceito = 1'b0;
        checks++;
        if (op_pronto !== 1'b0) begin errors++; $display("FAIL fill_bubble: op_pronto=%b required 0", op_pronto); end
        step();
        checks++;
        if (op_pronto !== 1'b1 || inicio !== 1'b1) begin
            errors++; $display("FAIL fill_free: op_pronto=%b inicio=%b required 1/1", op_pronto, inicio);
        end
        step();
        op_valido = 1'b0;
        res_aceito = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            wait_res(40);
            checks++;
            if (res !== poly(16'(k), 16'(k + 1), 16'd2, 16'(3 * k))) begin
                errors++;
                $display("FAIL fill_order: op %0d got %0d required %0d", k, res, poly(16'(k), 16'(k + 1), 16'd2, 16'(3 * k)));
            end
            step();
        end
        res_aceito = 1'b0;
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL fill_drain: ocupado=%b required 0", ocupado); end
    endtask

    task automatic test_led_long();
        dp_manual = 1'b1;
        man_led = 1'b0;
        push(16'd1, 16'd1, 16'd1, 16'd1);
        step();
        step();
        man_led = 1'b1;
        man_res = 16'hBEEF;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (pronto !== 1'b1 || res_valido !== 1'b0) begin
                errors++; $display("FAIL led_long_pronto: cycle %0d pronto=%b res_valido=%b required 1/0", i, pronto, res_valido);
            end
            if (i == 6) man_led = 1'b0;
        end
        step();
        checks++;
        if (pronto !== 1'b0 || res_valido !== 1'b1 || res !== 16'hBEEF) begin
            errors++;
            $display("FAIL led_long_saida: pronto=%b res_valido=%b res=%h required 0/1/beef", pronto, res_valido, res);
        end
        res_aceito = 1'b1;
        step();
        res_aceito = 1'b0;
    endtask

`ifdef MESTRE_POLINOMIO_TIMEOUT_EN
    task automatic test_timeout();
        man_led = 1'b0;
        push(16'd1, 16'd0, 16'd0, 16'd0);
        step();
        step();
        for (int i = 2; i <= 8; i++) step();
        checks++;
        if (pronto !== 1'b0 || erro !== 1'b0 || res_valido !== 1'b0) begin
            errors++; $display("FAIL to_wait: pronto=%b erro=%b res_valido=%b required 0/0/0", pronto, erro, res_valido);
        end
        step();
        checks++;
        if (pronto !== 1'b1 || erro !== 1'b1 || res !== 16'd0) begin
            errors++; $display("FAIL to_fire: pronto=%b erro=%b res=%h required 1/1/0", pronto, erro, res);
        end
        step();
        checks++;
        if (pronto !== 1'b0 || res_valido !== 1'b1 || res !== 16'd0) begin
            errors++; $display("FAIL to_saida: pronto=%b res_valido=%b res=%h required 0/1/0", pronto, res_valido, res);
        end
        res_aceito = 1'b1;
        step();
        res_aceito = 1'b0;
        dp_manual = 1'b0;
        push(16'd2, 16'd3, 16'd4, 16'd5);
        wait_res(30);
        checks++;
        if (res !== 16'd25 || erro !== 1'b1) begin
            errors++; $display("FAIL to_next: res=%0d erro=%b required 25/1", res, erro);
        end
        res_aceito = 1'b1;
        step();
        res_aceito = 1'b0;
        dp_manual = 1'b1;
    endtask
`endif

    task automatic test_reset_mid();
        man_led = 1'b0;
        push(16'd3, 16'd1, 16'd1, 16'd1);
        push(16'd4, 16'd1, 16'd1, 16'd1);
        step();
        step();
        checks++;
        if (ocupado !== 1'b1 || pronto !== 1'b0 || X !== 16'd3) begin
            errors++; $display("FAIL rmid_pre: ocupado=%b pronto=%b X=%0d required 1/0/3", ocupado, pronto, X);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if ({inicio, pronto, res_valido, erro, op_pronto, ocupado} !== 6'b000010) begin
            errors++;
            $display("FAIL rmid_flags: got %b required 000010", {inicio, pronto, res_valido, erro, op_pronto, ocupado});
        end
        checks++;
        if ({X, A, B, C, res} !== 80'd0) begin
            errors++; $display("FAIL rmid_data: got %h required 0", {X, A, B, C, res});
        end
        man_led = 1'b1;
        man_res = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (res_valido !== 1'b0 || inicio !== 1'b0 || pronto !== 1'b0 || ocupado !== 1'b0) begin
                errors++;
                $display("FAIL rmid_ignore: res_valido=%b inicio=%b pronto=%b ocupado=%b required 0", res_valido, inicio, pronto, ocupado);
            end
        end
        man_led = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0; op_valido = 1'b0; res_aceito = 1'b0;
        op_X = '0; op_A = '0; op_B = '0; op_C = '0;
        dp_manual = 1'b0; man_led = 1'b0; man_res = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_fifo_fill();
        test_led_long();
`ifdef MESTRE_POLINOMIO_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
